// File: rtl/fft_r22sdf_ctrl_if.sv
// Control bundle between the R2^2 SDF sequencer and the datapath it steers.
interface fft_r22sdf_ctrl_if #(
    parameter int unsigned LOG2N = 10
);
    logic                         valid_i;
    logic [LOG2N-1:0]             sel_o;
    logic [LOG2N/2-1:0]           jswap_o;
    logic [(LOG2N/2-1)*LOG2N-1:0] tw_exp_o;
    logic                         valid_o;
    logic                         sof_o;
    logic                         eof_o;
    logic                         busy_o;
    logic                         err_o;

    modport master (
        output valid_i,
        input  sel_o, jswap_o, tw_exp_o, valid_o, sof_o, eof_o, busy_o, err_o
    );

    modport slave (
        input  valid_i,
        output sel_o, jswap_o, tw_exp_o, valid_o, sof_o, eof_o, busy_o, err_o
    );
endinterface

// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for a radix-2^2 single-path delay-feedback FFT: frame index tracking, butterfly
// sel/-j controls, twiddle exponents and latency-aligned output framing.
module fft_r22sdf_ctrl #(
    parameter int unsigned LOG2N     = 10,
    parameter int unsigned STAGE_LAT = 1,
    parameter int unsigned MUL_LAT   = 2,
    parameter int unsigned TW_LAT    = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fft_r22sdf_ctrl_if.slave bus_io
);
    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned NMUL = LOG2N / 2 - 1;
    localparam int unsigned LAT  = N - 1 + LOG2N * STAGE_LAT + NMUL * MUL_LAT;
    localparam int unsigned CW   = $clog2(LAT + 1);
    localparam int unsigned TWW  = NMUL * LOG2N;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             r_state, w_state_d;
    logic [LOG2N-1:0]   r_ctr, w_ctr_d;
    logic [CW-1:0]      r_drain, w_drain_d;
    logic               r_err, w_err_d;
    logic               w_acc, w_flush;
    logic [LAT-1:0]     r_vchain, r_schain, r_echain;
    logic [LOG2N-1:0]   r_sel, w_sel_d;
    logic [LOG2N/2-1:0] r_jswap, w_jswap_d;
    logic [TWW-1:0]     r_tw, w_tw_d;
    logic [LOG2N-1:0]   w_p, w_q, w_br, w_r, w_e;

    always_comb begin
        w_state_d = r_state;
        w_ctr_d   = r_ctr;
        w_drain_d = r_drain;
        w_err_d   = r_err;
        w_acc     = 1'b0;
        w_flush   = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus_io.valid_i) begin
                    w_state_d = StRun;
                    w_ctr_d   = LOG2N'(1);
                    w_acc     = 1'b1;
                end
            end
            StRun: begin
                w_ctr_d = r_ctr + 1'b1;
                if (bus_io.valid_i) begin
                    w_acc = 1'b1;
                end else if (r_ctr == '0) begin
                    w_state_d = StDrain;
                    w_drain_d = CW'(LAT);
                end else begin
                    // Gap mid-frame: the delay lines are now misaligned, so drop everything.
                    w_err_d   = 1'b1;
                    w_state_d = StIdle;
                    w_ctr_d   = '0;
                    w_flush   = 1'b1;
                end
            end
            StDrain: begin
                w_ctr_d = r_ctr + 1'b1;
                if (bus_io.valid_i && (r_ctr == '0)) begin
                    w_acc     = 1'b1;
                    w_state_d = StRun;
                    w_drain_d = '0;
                end else begin
                    if (bus_io.valid_i) begin
                        w_err_d = 1'b1;
                    end
                    if (r_drain == CW'(1)) begin
                        w_state_d = StIdle;
                        w_drain_d = '0;
                        w_ctr_d   = '0;
                    end else begin
                        w_drain_d = r_drain - 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Controls are computed from the next index so the registered copy lines up with r_ctr.
    always_comb begin
        w_sel_d   = '0;
        w_jswap_d = '0;
        w_tw_d    = '0;
        w_p       = '0;
        w_q       = '0;
        w_br      = '0;
        w_r       = '0;
        w_e       = '0;
        if (w_state_d != StIdle) begin
            for (int k = 0; k < int'(LOG2N); k++) begin
                w_p        = w_ctr_d - LOG2N'(k * STAGE_LAT + (k / 2) * MUL_LAT);
                w_sel_d[k] = w_p[LOG2N-1-k];
            end
            for (int j = 0; j < int'(LOG2N / 2); j++) begin
                w_p          = w_ctr_d - LOG2N'((2 * j + 1) * STAGE_LAT + j * MUL_LAT);
                w_jswap_d[j] = &w_p[LOG2N-2*j-1 -: 2];
            end
            for (int j = 0; j < int'(NMUL); j++) begin
                w_q = w_ctr_d - LOG2N'((2 * j + 2) * STAGE_LAT + (j + 1) * MUL_LAT)
                    + LOG2N'(TW_LAT + MUL_LAT);
                w_br      = '0;
                w_br[1:0] = {w_q[LOG2N-2*j-2], w_q[LOG2N-2*j-1]};
                w_r       = w_q & LOG2N'((1 << (LOG2N - 2 * j - 2)) - 1);
                w_e       = (w_br * w_r) << (2 * j);
                w_tw_d[j*LOG2N +: LOG2N] = w_e;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_ctr    <= '0;
            r_drain  <= '0;
            r_err    <= 1'b0;
            r_vchain <= '0;
            r_schain <= '0;
            r_echain <= '0;
            r_sel    <= '0;
            r_jswap  <= '0;
            r_tw     <= '0;
        end else begin
            r_state <= w_state_d;
            r_ctr   <= w_ctr_d;
            r_drain <= w_drain_d;
            r_err   <= w_err_d;
            r_sel   <= w_sel_d;
            r_jswap <= w_jswap_d;
            r_tw    <= w_tw_d;
            if (w_flush) begin
                r_vchain <= '0;
                r_schain <= '0;
                r_echain <= '0;
            end else begin
                r_vchain <= {r_vchain[LAT-2:0], w_acc};
                r_schain <= {r_schain[LAT-2:0], w_acc & (r_ctr == '0)};
                r_echain <= {r_echain[LAT-2:0], w_acc & (&r_ctr)};
            end
        end
    end

    assign bus_io.sel_o    = r_sel;
    assign bus_io.jswap_o  = r_jswap;
    assign bus_io.tw_exp_o = r_tw;
    assign bus_io.valid_o  = r_vchain[LAT-1];
    assign bus_io.sof_o    = r_schain[LAT-1];
    assign bus_io.eof_o    = r_echain[LAT-1];
    assign bus_io.busy_o   = (r_state != StIdle);
    assign bus_io.err_o    = r_err;
endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Scoreboard bench for fft_r22sdf_ctrl at N=16: output framing timed against a queue of
// expected samples, butterfly controls checked against golden per-index tables.
module tb_fft_r22sdf_ctrl;
    localparam int unsigned LOG2N = 4;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t0;

    typedef struct {
        int   due;
        logic sof;
        logic eof;
    } exp_t;
    exp_t sb[$];

    // Per-index golden values for a first frame out of IDLE (index 0 is all-zero).
    logic [15:0] g_sel0 = 16'hFF00;
    logic [15:0] g_sel1 = 16'hE1E0;
    logic [15:0] g_sel2 = 16'h6666;
    logic [15:0] g_sel3 = 16'hAAAA;
    logic [15:0] g_js0  = 16'hE000;
    logic [15:0] g_js1  = 16'h8888;
    int          g_tw[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_r22sdf_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_r22sdf_ctrl #(
        .LOG2N    (LOG2N),
        .STAGE_LAT(1),
        .MUL_LAT  (1),
        .TW_LAT   (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Discard expectations the DUT is about to flush (reset or mid-frame abort).
    task automatic sb_drop_future();
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check_eq("valid_o", {31'b0, bus.valid_o}, 32'd1);
                check_eq("sof_o", {31'b0, bus.sof_o}, {31'b0, sb[0].sof});
                check_eq("eof_o", {31'b0, bus.eof_o}, {31'b0, sb[0].eof});
                void'(sb.pop_front());
            end else begin
                check_eq("valid_o_quiet", {29'b0, bus.valid_o, bus.sof_o, bus.eof_o}, 32'd0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int len, input bit chk);
        for (int i = 0; i < len; i++) begin
            bus.valid_i = 1'b1;
            sb.push_back('{due: cyc + LAT, sof: (i % 16) == 0, eof: (i % 16) == 15});
            @(negedge clk);
            if (chk) begin
                if (i == 0) begin
                    check_eq("ctrl_idx0", {20'b0, bus.sel_o, bus.jswap_o, 2'b0, bus.tw_exp_o},
                             32'd0);
                end else begin
                    check_eq("sel_o", {28'b0, bus.sel_o},
                             {28'b0, g_sel3[i], g_sel2[i], g_sel1[i], g_sel0[i]});
                    check_eq("jswap_o", {30'b0, bus.jswap_o}, {30'b0, g_js1[i], g_js0[i]});
                    check_eq("tw_exp_o", {28'b0, bus.tw_exp_o}, g_tw[i-1]);
                end
            end
            next_cycle();
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) begin
            @(negedge clk);
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle after reset: every control output low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_ctrl", {20'b0, bus.sel_o, bus.jswap_o, 2'b0, bus.tw_exp_o}, 32'd0);
            check_eq("idle_busy_err", {30'b0, bus.busy_o, bus.err_o}, 32'd0);
            next_cycle();
        end

        // Single frame with control sequence checks; busy must outlast the output frame.
        t0 = cyc;
        frame(16, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cyc == t0 + 35) check_eq("busy_last_out", {31'b0, bus.busy_o}, 32'd1);
            if (cyc == t0 + 40) check_eq("busy_after_drain", {31'b0, bus.busy_o}, 32'd0);
            next_cycle();
        end
        check_eq("idle_sel_after", {28'b0, bus.sel_o}, 32'd0);

        // Three back-to-back frames.
        frame(48, 1'b0);
        idle(45);

        // Gap at index 5: sticky error, back to IDLE, frame never emerges.
        frame(5, 1'b0);
        bus.valid_i = 1'b0;
        sb_drop_future();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check_eq("gap_err", {31'b0, bus.err_o}, 32'd1);
        check_eq("gap_busy", {31'b0, bus.busy_o}, 32'd0);
        next_cycle();
        idle(30);
        @(negedge clk);
        check_eq("err_sticky", {31'b0, bus.err_o}, 32'd1);
        next_cycle();
        rst = 1'b1;
        sb_drop_future();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", {31'b0, bus.err_o}, 32'd0);
        next_cycle();

        // Reset in the middle of DRAIN, then a clean frame.
        frame(16, 1'b1);
        idle(10);
        rst = 1'b1;
        sb_drop_future();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_drain_ctrl", {20'b0, bus.sel_o, bus.jswap_o, 2'b0, bus.tw_exp_o}, 32'd0);
        check_eq("rst_drain_busy", {30'b0, bus.busy_o, bus.err_o}, 32'd0);
        next_cycle();
        frame(16, 1'b1);
        idle(45);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
